// File: rtl/msdf_mul_online.sv
// Radix-2 MSDF online serial-serial multiplier with frame handshake.
// Consumes one signed-digit pair per step, emits N product digits after
// DELTA initialisation steps; W, X and Y are two's complement with F
// fractional bits (F = RW-2).
module msdf_mul_online #(
    parameter int N     = 8,
    parameter int DELTA = 3,
    parameter int RW    = N + DELTA + 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] xj,
    input  logic [1:0] yj,
    output logic       in_ready,
    output logic [1:0] Zj,
    output logic       ready_Zj,
    output logic       z_last,
    output logic       busy
);

    localparam logic [1:0] R2_ZERO    = 2'b00;
    localparam logic [1:0] R2_POS_ONE = 2'b01;
    localparam logic [1:0] R2_NEG_ONE = 2'b10;

    localparam int F  = RW - 2;
    localparam int KW = $clog2(N + DELTA + 1);

    localparam logic [KW-1:0] K_LOAD_END = KW'(N - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(N + DELTA - 1);
    localparam logic [KW-1:0] K_DELTA    = KW'(DELTA);
    localparam logic [KW-1:0] K_FM1      = KW'(F - 1);

    localparam logic signed [RW-1:0] HALF = {2'b00, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [RW-1:0] ONE  = {2'b01, {F{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic signed [RW-1:0]   w_q, w_d;
    logic signed [RW-1:0]   xa_q, xa_d;
    logic signed [RW-1:0]   ya_q, ya_d;
    logic [KW-1:0]          k_q, k_d;
    logic [1:0]             zj_q, zj_d;
    logic                   zv_q, zv_d;
    logic                   zl_q, zl_d;

    logic                   step;
    logic                   sel;
    logic [1:0]             x_dig, y_dig, z_dig;
    logic [KW-1:0]          shamt;
    logic signed [RW-1:0]   pos, xa_n, ya_n, term, v, w_sel;

    // Multiply a residual-format value by a signed digit; 2'b11 counts as zero.
    function automatic logic signed [RW-1:0] sd_mul(input logic [1:0] d,
                                                    input logic signed [RW-1:0] a);
        case (d)
            R2_POS_ONE: sd_mul = a;
            R2_NEG_ONE: sd_mul = -a;
            default:    sd_mul = '0;
        endcase
    endfunction

    // Registers: FSM, residual, operand accumulators, step counter, output digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            k_q     <= '0;
            zj_q    <= R2_ZERO;
            zv_q    <= 1'b0;
            zl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            k_q     <= k_d;
            zj_q    <= zj_d;
            zv_q    <= zv_d;
            zl_q    <= zl_d;
        end
    end

    // One recurrence step: accumulate operands, form v, select digit, next state.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        k_d     = k_q;
        zj_d    = R2_ZERO;
        zv_d    = 1'b0;
        zl_d    = 1'b0;

        step  = (state_q == LOAD && in_valid) || (state_q == FLUSH);
        sel   = (k_q >= K_DELTA);
        x_dig = (state_q == LOAD) ? xj : R2_ZERO;
        y_dig = (state_q == LOAD) ? yj : R2_ZERO;

        // Weight 2^-(k+1); shamt only matters in LOAD, where it is non-negative.
        shamt = K_FM1 - k_q;
        pos   = {{(RW-1){1'b0}}, 1'b1} << shamt;
        xa_n  = xa_q + sd_mul(x_dig, pos);
        ya_n  = ya_q + sd_mul(y_dig, pos);
        // X/Y have no bits below weight 2^-N, so the DELTA shift is exact.
        term  = sd_mul(x_dig, ya_n) + sd_mul(y_dig, xa_q);
        v     = (w_q <<< 1) + (term >>> DELTA);

        if (v >= HALF) begin
            z_dig = R2_POS_ONE;
            w_sel = v - ONE;
        end else if (v < -HALF) begin
            z_dig = R2_NEG_ONE;
            w_sel = v + ONE;
        end else begin
            z_dig = R2_ZERO;
            w_sel = v;
        end

        case (state_q)
            IDLE: begin
                // The z_last cycle still counts as busy, so start is dropped there.
                if (start && !zl_q) begin
                    w_d     = '0;
                    xa_d    = '0;
                    ya_d    = '0;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD, FLUSH: begin
                if (step) begin
                    w_d  = sel ? w_sel : v;
                    xa_d = xa_n;
                    ya_d = ya_n;
                    k_d  = k_q + 1'b1;
                    if (sel) begin
                        zj_d = z_dig;
                        zv_d = 1'b1;
                        zl_d = (k_q == K_LAST);
                    end
                    if (state_q == LOAD && k_q == K_LOAD_END) begin
                        state_d = FLUSH;
                    end else if (state_q == FLUSH && k_q == K_LAST) begin
                        // Start on the final flush step opens the next frame directly.
                        if (start) begin
                            w_d     = '0;
                            xa_d    = '0;
                            ya_d    = '0;
                            k_d     = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == LOAD);
    assign Zj       = zj_q;
    assign ready_Zj = zv_q;
    assign z_last   = zl_q;
    assign busy     = (state_q != IDLE) || zl_q;

endmodule

// File: tb/tb_msdf_mul_online.sv
// Scoreboard bench for msdf_mul_online: drivers push expected pulse cycles
// and products, negedge monitors pop and compare.
module tb_msdf_mul_online;

    localparam int NA = 8;
    localparam int DA = 3;
    localparam int NB = 16;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, inv_a, inr_a, rz_a, zl_a, busy_a;
    logic [1:0] xj_a, yj_a, zj_a;
    logic       start_b, inv_b, inr_b, rz_b, zl_b, busy_b;
    logic [1:0] xj_b, yj_b, zj_b;

    msdf_mul_online #(.N(NA), .DELTA(DA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(inv_a),
        .xj(xj_a), .yj(yj_a), .in_ready(inr_a), .Zj(zj_a),
        .ready_Zj(rz_a), .z_last(zl_a), .busy(busy_a)
    );

    msdf_mul_online #(.N(NB), .DELTA(DB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(inv_b),
        .xj(xj_b), .yj(yj_b), .in_ready(inr_b), .Zj(zj_b),
        .ready_Zj(rz_b), .z_last(zl_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint expA_prod[$];
    int     expA_cyc[$];
    longint expB_prod[$];

    int s1x[NA] = '{1, 1, -1, 0, 1, -1, 0, 1};
    int s1y[NA] = '{1, 0, 1, -1, -1, 1, 1, 0};
    int s2x[NA] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int s3x[NA] = '{-1, -1, -1, -1, -1, -1, -1, -1};
    int s3y[NA] = '{1, 1, 1, 1, 1, 1, 1, 1};

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp,
                             input longint tol);
        longint d;
        n_vec++;
        d = act - exp;
        if (d >= tol || d <= -tol) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d within +-%0d", name, act, exp, tol);
        end
    endtask

    task automatic fail(input string name, input longint act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d required none (t=%0t)", name, act, $time);
    endtask

    function automatic logic [1:0] enc(input int d);
        if (d > 0) return 2'b01;
        if (d < 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int dec(input logic [1:0] z);
        if (z == 2'b01) return 1;
        if (z == 2'b10) return -1;
        return 0;
    endfunction

    // Monitor A: pulse timing, z_last position, idle zeroing and frame value.
    int     pcnt_a = 0;
    longint zacc_a = 0;
    always @(negedge clk) begin
        if (!rst) begin
            pcnt_a = 0;
            zacc_a = 0;
        end else if (rz_a) begin
            pcnt_a++;
            zacc_a = zacc_a * 2 + dec(zj_a);
            if (expA_cyc.size() == 0) fail("pulse_unexpected_a", cyc);
            else check("pulse_cycle_a", cyc, expA_cyc.pop_front());
            check("z_last_a", zl_a, (pcnt_a == NA));
            if (pcnt_a == NA) begin
                if (expA_prod.size() == 0) fail("frame_unexpected_a", zacc_a);
                else check_tol("value_a", zacc_a * (64'sd1 << NA), expA_prod.pop_front(),
                               64'sd1 << NA);
                pcnt_a = 0;
                zacc_a = 0;
            end
        end else begin
            if (zj_a != 2'b00) check("zj_idle_a", zj_a, 0);
            if (zl_a) check("z_last_idle_a", zl_a, 0);
        end
    end

    // Monitor B: digit count and frame value for the regression instance.
    int     pcnt_b = 0;
    longint zacc_b = 0;
    always @(negedge clk) begin
        if (!rst) begin
            pcnt_b = 0;
            zacc_b = 0;
        end else if (rz_b) begin
            pcnt_b++;
            zacc_b = zacc_b * 2 + dec(zj_b);
            if (pcnt_b == NB || zl_b) begin
                check("z_last_b", zl_b, (pcnt_b == NB));
                if (expB_prod.size() == 0) fail("frame_unexpected_b", zacc_b);
                else check_tol("value_b", zacc_b * (64'sd1 << NB), expB_prod.pop_front(),
                               64'sd1 << NB);
                pcnt_b = 0;
                zacc_b = 0;
            end
        end else if (zj_b != 2'b00) begin
            check("zj_idle_b", zj_b, 0);
        end
    end

    // Drive ndig pairs into A (already in LOAD); optional stall and ignored start.
    task automatic send_a(input int xs[NA], input int ys[NA], input longint prod,
                          input int stall_at, input int stall_n, input int ndig,
                          input bit poke_start);
        expA_prod.push_back(prod);
        for (int i = 0; i < ndig; i++) begin
            if (i == stall_at) begin
                inv_a = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("in_ready_stall", inr_a, 1);
                    @(posedge clk); #1;
                end
            end
            inv_a   = 1'b1;
            xj_a    = enc(xs[i]);
            yj_a    = enc(ys[i]);
            start_a = poke_start && (i == 2);
            check("in_ready_load", inr_a, 1);
            if (i >= DA) expA_cyc.push_back(cyc + 1);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        inv_a   = 1'b0;
        xj_a    = 2'b00;
        yj_a    = 2'b00;
        if (ndig == NA) begin
            check("in_ready_flush", inr_a, 0);
            for (int j = 1; j <= DA; j++) expA_cyc.push_back(cyc + j);
        end
    endtask

    task automatic drain_a();
        repeat (DA + 3) @(posedge clk);
        #1;
        check("busy_idle", busy_a, 0);
        check("pulses_pending", expA_cyc.size(), 0);
        check("frames_pending", expA_prod.size(), 0);
    endtask

    task automatic frame_a(input int xs[NA], input int ys[NA], input longint prod,
                           input int stall_at, input int stall_n);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("busy_after_start", busy_a, 1);
        send_a(xs, ys, prod, stall_at, stall_n, NA, 1'b0);
        drain_a();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     xb[NB];
        int     yb[NB];
        longint xi, yi;

        rst = 1'b0;
        start_a = 1'b0; inv_a = 1'b0; xj_a = 2'b00; yj_a = 2'b00;
        start_b = 1'b0; inv_b = 1'b0; xj_b = 2'b00; yj_b = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_zj", zj_a, 0);
        check("reset_ready_zj", rz_a, 0);
        check("reset_z_last", zl_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_in_ready", inr_a, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 165/256 * 142/256, then 1/2 * 1/2, then -(255/256)*(255/256)
        frame_a(s1x, s1y, 64'sd23430, -1, 0);
        frame_a(s2x, s2x, 64'sd16384, -1, 0);
        frame_a(s3x, s3y, -64'sd65025, -1, 0);

        // Same as first frame with a 3-cycle stall after digit 3
        frame_a(s1x, s1y, 64'sd23430, 3, 3);

        // Back-to-back: start on the final flush cycle; start mid-LOAD ignored
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        send_a(s1x, s1y, 64'sd23430, -1, 0, NA, 1'b1);
        repeat (DA - 1) begin
            @(posedge clk); #1;
        end
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("in_ready_b2b", inr_a, 1);
        check("busy_b2b", busy_a, 1);
        send_a(s3x, s3y, -64'sd65025, -1, 0, NA, 1'b0);
        drain_a();

        // Asynchronous reset after digit 5 of a frame
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        send_a(s1x, s1y, 64'sd23430, -1, 0, 5, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_zj", zj_a, 0);
        check("midreset_ready_zj", rz_a, 0);
        check("midreset_z_last", zl_a, 0);
        check("midreset_busy", busy_a, 0);
        check("midreset_in_ready", inr_a, 0);
        expA_cyc.delete();
        expA_prod.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_busy", busy_a, 0);
        frame_a(s1x, s1y, 64'sd23430, -1, 0);

        // N=16, DELTA=4 regression with random operands
        for (int f = 0; f < 1000; f++) begin
            xi = 0;
            yi = 0;
            for (int i = 0; i < NB; i++) begin
                xb[i] = int'($urandom_range(2)) - 1;
                yb[i] = int'($urandom_range(2)) - 1;
                xi = xi * 2 + xb[i];
                yi = yi * 2 + yb[i];
            end
            expB_prod.push_back(xi * yi);
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            for (int i = 0; i < NB; i++) begin
                inv_b = 1'b1;
                xj_b = (xb[i] == 0 && $urandom_range(1) == 1) ? 2'b11 : enc(xb[i]);
                yj_b = (yb[i] == 0 && $urandom_range(1) == 1) ? 2'b11 : enc(yb[i]);
                @(posedge clk); #1;
            end
            inv_b = 1'b0;
            xj_b  = 2'b00;
            yj_b  = 2'b00;
            repeat (DB + 2) @(posedge clk);
            #1;
        end
        check("frames_pending_b", expB_prod.size(), 0);
        check("busy_idle_b", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
